// File: rtl/mem_access_unit_if.sv
// Bus bundle between the MEM-stage access unit, the EX/MEM register and the data port.
// master = access unit, slave = pipeline/memory side.
interface mem_access_unit_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [15:0] addr;
  logic [15:0] st_data;
  logic        flush;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic [15:0] mem_data;
  logic        mem_done;
  logic        mem_stall;

  modport master (
    input  op_valid, op, addr, st_data, flush, mem_resp, mem_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
           mem_data, mem_done, mem_stall
  );

  modport slave (
    output op_valid, op, addr, st_data, flush, mem_resp, mem_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
           mem_data, mem_done, mem_stall
  );
endinterface

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage initiator: sequences LDR/LDB/STR/STB and two-phase LDI/STI on the data port.
// Define MEM_PERF_CNT_EN to add the saturating stall_cycles counter.
module mem_access_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_access_unit_if.master bus
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);

  if (CNT_WIDTH < 2) begin : g_cnt_width_check
    $error("CNT_WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_INDIRECT,
    S_ACCESS,
    S_DONE
  } state_e;

  typedef struct packed {
    logic is_mem;
    logic is_load;
    logic is_byte;
    logic is_ind;
  } op_dec_t;

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] data_q, data_d;
  logic        squash_q, squash_d;

  op_dec_t     dec;
  logic [15:0] acc_addr;
  logic [7:0]  lane;
  logic [15:0] load_val;

  logic        rd, wr, done, stall;
  logic [1:0]  be;
  logic [15:0] adr, wd;

  always_comb begin
    dec = '0;
    unique case (bus.op)
      3'b001:  dec = '{is_mem: 1'b1, is_load: 1'b1, is_byte: 1'b0, is_ind: 1'b0};
      3'b010:  dec = '{is_mem: 1'b1, is_load: 1'b1, is_byte: 1'b1, is_ind: 1'b0};
      3'b011:  dec = '{is_mem: 1'b1, is_load: 1'b0, is_byte: 1'b0, is_ind: 1'b0};
      3'b100:  dec = '{is_mem: 1'b1, is_load: 1'b0, is_byte: 1'b1, is_ind: 1'b0};
      3'b101:  dec = '{is_mem: 1'b1, is_load: 1'b1, is_byte: 1'b0, is_ind: 1'b1};
      3'b110:  dec = '{is_mem: 1'b1, is_load: 1'b0, is_byte: 1'b0, is_ind: 1'b1};
      default: dec = '0;
    endcase
  end

  // Second-phase address of an indirect op comes from the fetched pointer.
  assign acc_addr = dec.is_ind ? ptr_q : bus.addr;
  assign lane     = acc_addr[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
  assign load_val = dec.is_byte ? {{8{lane[7]}}, lane} : bus.mem_rdata;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    squash_d = squash_q;
    rd       = 1'b0;
    wr       = 1'b0;
    be       = 2'b00;
    adr      = 16'h0000;
    wd       = 16'h0000;
    done     = 1'b0;
    stall    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        squash_d = 1'b0;
        if (bus.op_valid && !bus.flush) begin
          if (dec.is_mem) begin
            stall   = 1'b1;
            state_d = dec.is_ind ? S_INDIRECT : S_ACCESS;
          end else begin
            done = 1'b1;
          end
        end
      end

      S_INDIRECT: begin
        stall = 1'b1;
        rd    = 1'b1;
        adr   = {bus.addr[15:1], 1'b0};
        if (bus.flush) squash_d = 1'b1;
        if (bus.mem_resp) begin
          ptr_d   = bus.mem_rdata;
          // A squashed indirect never issues its second phase.
          state_d = (bus.flush || squash_q) ? S_DONE : S_ACCESS;
        end
      end

      S_ACCESS: begin
        stall = 1'b1;
        adr   = dec.is_byte ? acc_addr : {acc_addr[15:1], 1'b0};
        if (dec.is_load) begin
          rd = 1'b1;
        end else begin
          wr = 1'b1;
          be = dec.is_byte ? (acc_addr[0] ? 2'b10 : 2'b01) : 2'b11;
          wd = dec.is_byte ? {2{bus.st_data[7:0]}} : bus.st_data;
        end
        if (bus.flush) squash_d = 1'b1;
        if (bus.mem_resp) begin
          state_d = S_DONE;
          if (dec.is_load && !bus.flush && !squash_q) data_d = load_val;
        end
      end

      S_DONE: begin
        done    = !squash_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 16'h0000;
      data_q   <= 16'h0000;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      squash_q <= squash_d;
    end
  end

  // Handshake outputs are forced low while reset is held so they drop asynchronously.
  assign bus.mem_read        = rd;
  assign bus.mem_write       = wr;
  assign bus.mem_byte_enable = be;
  assign bus.mem_address     = adr;
  assign bus.mem_wdata       = wd;
  assign bus.mem_data        = data_q;
  assign bus.mem_done        = done && reset_n;
  assign bus.mem_stall       = stall && reset_n;

`ifdef MEM_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a bus responder inside run_op and a queue of expected load results.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model_data = 16'h0000;
  int          stall_n, done_n, done_k, stall_seen;
  int          strobe_n[2];
  logic        obs_rd[2];
  logic        obs_wr[2];

  mem_access_unit_if bus();

`ifdef MEM_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  mem_access_unit #(.CNT_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef MEM_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op at the next cycle and answers each strobe after dly extra cycles.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] sd,
                        input logic [15:0] rd0, input logic [15:0] rd1,
                        input int dly, input int flush_at,
                        input logic [15:0] ea0, input logic [15:0] ea1,
                        input logic [15:0] ewd, input logic [1:0] ebe);
    int ph, w;
    stall_n = 0; done_n = 0; done_k = -1; ph = 0; w = 0;
    for (int i = 0; i < 2; i++) begin
      strobe_n[i] = 0; obs_rd[i] = 1'b0; obs_wr[i] = 1'b0;
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      bus.mem_resp = 1'b0;
      bus.flush    = (k == flush_at);
      if (k == 0) begin
        bus.op_valid = 1'b1; bus.op = o; bus.addr = a; bus.st_data = sd;
      end
      #1;
      if (bus.mem_stall) begin stall_n++; stall_seen++; end
      if (bus.mem_done) begin
        done_n++; done_k = k;
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("mem_data", bus.mem_data, exp_q.pop_front());
      end
      if ((bus.mem_read || bus.mem_write) && ph < 2) begin
        if (strobe_n[ph] == 0) begin
          obs_rd[ph] = bus.mem_read; obs_wr[ph] = bus.mem_write;
        end
        chk(ph == 0 ? "addr_p0" : "addr_p1", bus.mem_address, ph == 0 ? ea0 : ea1);
        if (bus.mem_write) begin
          chk("wdata", bus.mem_wdata, ewd);
          chk("byte_en", bus.mem_byte_enable, ebe);
        end
        strobe_n[ph]++;
        if (w == dly) begin
          bus.mem_resp = 1'b1; bus.mem_rdata = (ph == 0) ? rd0 : rd1; ph++; w = 0;
        end else begin
          w++;
        end
      end
      if (k > 0 && !bus.mem_stall) return;
    end
    chk("timeout", 1, 0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op = 3'b000; bus.flush = 1'b0; bus.mem_resp = 1'b0;
  endtask

  initial begin
    stall_seen = 0;
    bus.op_valid = 1'b0; bus.op = 3'b000; bus.addr = 16'h0000; bus.st_data = 16'h0000;
    bus.flush = 1'b0; bus.mem_resp = 1'b0; bus.mem_rdata = 16'h0000;
    #2;
    chk("rst_ctrl", {bus.mem_read, bus.mem_write, bus.mem_byte_enable, bus.mem_done, bus.mem_stall}, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_data", bus.mem_data, 0);
    @(negedge clk); reset_n = 1'b1;

    // LDR, response in the first strobe cycle
    exp_q.push_back(16'hBEEF); model_data = 16'hBEEF;
    run_op(3'b001, 16'h1235, 16'h0, 16'hBEEF, 16'h0, 0, -1, 16'h1234, 16'h0, 16'h0, 2'b00);
    chk("ldr_stall_n", stall_n, 2);
    chk("ldr_done_k", done_k, 2);
    chk("ldr_strobes", strobe_n[0], 1);
    chk("ldr_is_read", obs_rd[0], 1);
    chk("ldr_done_n", done_n, 1);

    // LDB, both lanes, back to back
    exp_q.push_back(16'hFF80); model_data = 16'hFF80;
    run_op(3'b010, 16'h2001, 16'h0, 16'h80FF, 16'h0, 0, -1, 16'h2001, 16'h0, 16'h0, 2'b00);
    chk("ldb_hi_done_n", done_n, 1);
    exp_q.push_back(16'hFFFF); model_data = 16'hFFFF;
    run_op(3'b010, 16'h2000, 16'h0, 16'h80FF, 16'h0, 0, -1, 16'h2000, 16'h0, 16'h0, 2'b00);
    chk("ldb_lo_done_n", done_n, 1);
    idle();

    // STB, upper lane, response after 2 wait cycles
    exp_q.push_back(model_data);
    run_op(3'b100, 16'h3001, 16'h00A5, 16'h0, 16'h0, 2, -1, 16'h3001, 16'h0, 16'hA5A5, 2'b10);
    chk("stb_strobes", strobe_n[0], 3);
    chk("stb_is_write", obs_wr[0], 1);
    chk("stb_stall_n", stall_n, 4);
    chk("stb_done_n", done_n, 1);
    idle();

    // STI: pointer read then word write
    exp_q.push_back(model_data);
    run_op(3'b110, 16'h4000, 16'h1234, 16'h5002, 16'h0, 0, -1, 16'h4000, 16'h5002, 16'h1234, 2'b11);
    chk("sti_p0_read", obs_rd[0], 1);
    chk("sti_p1_write", obs_wr[1], 1);
    chk("sti_stall_n", stall_n, 3);
    chk("sti_done_n", done_n, 1);
    idle();

    // LDI with odd addresses and one wait cycle per phase
    exp_q.push_back(16'h1357); model_data = 16'h1357;
    run_op(3'b101, 16'h6001, 16'h0, 16'h0103, 16'h1357, 1, -1, 16'h6000, 16'h0102, 16'h0, 2'b00);
    chk("ldi_p1_read", obs_rd[1], 1);
    chk("ldi_stall_n", stall_n, 5);
    chk("ldi_done_k", done_k, 5);
    idle();

    // LDR squashed while waiting on a slow response
    run_op(3'b001, 16'h1111, 16'h0, 16'hCAFE, 16'h0, 5, 2, 16'h1110, 16'h0, 16'h0, 2'b00);
    chk("fl_done_n", done_n, 0);
    chk("fl_strobes", strobe_n[0], 6);
    chk("fl_stall_n", stall_n, 7);
    chk("fl_data_kept", bus.mem_data, model_data);
    idle();

    // LDI squashed during the pointer read: no second phase
    run_op(3'b101, 16'h7000, 16'h0, 16'h7777, 16'h0, 0, 1, 16'h7000, 16'h0, 16'h0, 2'b00);
    chk("fli_p1_strobes", strobe_n[1], 0);
    chk("fli_done_n", done_n, 0);
    chk("fli_stall_n", stall_n, 2);
    chk("fli_data_kept", bus.mem_data, model_data);
    idle();

    // flush in the arrival cycle
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 3'b001; bus.addr = 16'h2222; bus.flush = 1'b1; #1;
    chk("arr_flush_ctrl", {bus.mem_read, bus.mem_stall, bus.mem_done}, 0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.flush = 1'b0; #1;
    chk("arr_flush_idle", {bus.mem_read, bus.mem_stall}, 0);

    // non-memory ops complete combinationally
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 3'b000; #1;
    chk("nm_done", {bus.mem_done, bus.mem_stall}, 2'b10);
    bus.flush = 1'b1; #1;
    chk("nm_flush_done", bus.mem_done, 0);
    bus.flush = 1'b0; bus.op = 3'b111; #1;
    chk("op7_done", {bus.mem_done, bus.mem_stall, bus.mem_read, bus.mem_write}, 4'b1000);
    bus.op_valid = 1'b0; #1;
    chk("nv_done", bus.mem_done, 0);

    // stray response while idle
    bus.mem_resp = 1'b1; bus.mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    bus.mem_resp = 1'b0; #1;
    chk("idle_resp_data", bus.mem_data, model_data);
    chk("idle_resp_ctrl", {bus.mem_read, bus.mem_stall}, 0);

`ifdef MEM_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, stall_seen);
`endif

    // reset pulsed mid-ACCESS
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op = 3'b001; bus.addr = 16'h1000;
    @(posedge clk); #2;
    chk("mid_read", bus.mem_read, 1);
    reset_n = 1'b0; #1;
    chk("mid_rst_ctrl", {bus.mem_read, bus.mem_write, bus.mem_byte_enable, bus.mem_done, bus.mem_stall}, 0);
    chk("mid_rst_addr", bus.mem_address, 0);
    chk("mid_rst_data", bus.mem_data, 0);
    model_data = 16'h0000;
    @(posedge clk); #3;
    bus.op = 3'b000; reset_n = 1'b1; #1;
    chk("post_rst_nm", {bus.mem_done, bus.mem_stall, bus.mem_read}, 3'b100);
    idle(); #1;
    chk("post_rst_idle", {bus.mem_read, bus.mem_stall}, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the pipelined LC-3b. It sits between the EX/MEM pipeline register and the data-memory/cache port, and produces the data that the MEM/WB register captures.
- Sequences LDR/STR/LDB/STB and the two-phase indirect LDI/STI accesses.
- Drives mem_done as the MEM/WB load and mem_stall to freeze the upstream stages.

Parameters:
- CNT_WIDTH, 16, width of the optional stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- op_valid  in  1  EX/MEM holds a valid instruction
- op  in  3  000 none, 001 LDR, 010 LDB, 011 STR, 100 STB, 101 LDI, 110 STI; others treated as none
- addr  in  16  effective address from the ALU
- st_data  in  16  store source register value
- flush  in  1  squash the current instruction (branch mispredict)
- mem_read  out  1  data-port read strobe
- mem_write  out  1  data-port write strobe
- mem_byte_enable  out  2  byte lanes for the write
- mem_address  out  16  data-port address
- mem_wdata  out  16  data-port write data
- mem_resp  in  1  data-port completion, one-cycle pulse
- mem_rdata  in  16  data-port read data, valid with mem_resp
- mem_data  out  16  load result to MEM/WB, registered
- mem_done  out  1  MEM/WB load enable
- mem_stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM
- stall_cycles  out  CNT_WIDTH  present only with MEM_PERF_CNT_EN

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; mem_read, mem_write, mem_done, mem_stall = 0; mem_byte_enable=0; mem_address, mem_wdata, mem_data = 0; stall_cycles=0.
- Non-memory op, or op_valid=0:
  - mem_done = op_valid & ~flush, combinational in the same cycle.
  - mem_stall=0; no memory strobes.
  - mem_data holds its previous value.
- Memory op in IDLE:
  - mem_stall=1 combinationally in the arrival cycle.
  - Next state ACCESS, or INDIRECT for LDI/STI.
  - Upstream holds op, addr and st_data stable while mem_stall=1.
- INDIRECT:
  - Outputs: mem_read=1, mem_address={addr[15:1],0}.
  - On mem_resp: latch the pointer = mem_rdata, go to ACCESS.
- ACCESS:
  - Address is the pointer for LDI/STI, addr otherwise.
  - Word ops force bit0 to 0.
  - Byte ops present the full address with bit0 intact.
- LDR/LDI: mem_read=1; on mem_resp, mem_data <= mem_rdata.
- LDB: mem_read=1; on mem_resp, mem_data <= sign-extended byte, with lane chosen by address bit0 (0 = [7:0], 1 = [15:8]).
- STR/STI: mem_write=1; mem_byte_enable=2'b11; mem_wdata=st_data.
- STB:
  - mem_write=1; mem_wdata={st_data[7:0],st_data[7:0]}.
  - mem_byte_enable = 2'b01 if bit0=0, else 2'b10.
- On final mem_resp:
  - Go to DONE; strobes drop in the next cycle.
- DONE:
  - mem_done=1 and mem_stall=0 for exactly one cycle; then IDLE.
  - A new op may be accepted in the cycle after DONE.
- Latency: 3 cycles minimum for a single access (arrival, resp, done) when mem_resp returns in the first strobe cycle; 4 cycles minimum for indirect.
- Strobes are held continuously until mem_resp; mem_address and mem_wdata are stable throughout.
- flush during INDIRECT or ACCESS:
  - The bus transaction in flight completes; it is never abandoned.
  - Any remaining indirect phase is skipped.
  - A squash flag is set; DONE then gives mem_done=0 and mem_data unchanged, mem_stall=0; return to IDLE.
- flush in the arrival cycle: no access is issued; mem_stall=0; remain in IDLE.
- mem_resp while IDLE or DONE: ignored.
- Reset mid-access: abort immediately; all strobes drop asynchronously.

Optional Feature:
- MEM_PERF_CNT_EN defined:
  - stall_cycles increments on every clk edge where mem_stall=1 and saturates at all-ones.
  - Cleared only by reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- LDR, addr=0x1235, mem_rdata=0xBEEF, resp in the first strobe cycle:
  - mem_address=0x1234, mem_read held 1 cycle.
  - mem_done pulses 2 cycles after arrival with mem_data=0xBEEF.
  - mem_stall high for exactly 2 cycles.
- LDB at 0x2001, rdata=0x80FF -> mem_data=0xFF80; at 0x2000 -> mem_data=0xFFFF.
- STB, addr=0x3001, st_data=0x00A5 -> mem_wdata=0xA5A5, mem_byte_enable=2'b10, mem_write until resp, then mem_done pulse.
- STI, addr=0x4000:
  - The first read returns 0x5002.
  - Second phase: mem_address=0x5002, mem_write=1, mem_byte_enable=2'b11, mem_wdata=st_data.
  - Exactly one mem_done.
- LDR with resp delayed 5 cycles and flush asserted in cycle 2:
  - mem_read is held until resp.
  - mem_done never rises; mem_data keeps its old value; mem_stall drops after resp.
- reset_n pulsed low mid-ACCESS -> all outputs 0 asynchronously, then IDLE. A following op=000 with op_valid=1 gives mem_done=1 in the same cycle.
